bch_encoder: RTL and testbench
==============================

Name: bch_encoder

Overview:
- Systematic BCH(63,51), t=2 encoder over GF(2^6), primitive polynomial x^6+x+1.
- The transmit-side counterpart to the bch_decoder receive path.
- Accepts a 51-bit message word, then streams the 63-bit codeword serially, MSB (x^62) first, through a valid/ready handshake.
- Also presents the full codeword in parallel when encoding finishes.

Parameters:
- K, 51, message length in bits (fixed by code; not for override)
- N, 63, codeword length in bits
- GEN_POLY, 12'h539, low 12 coefficients of g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1 (x^12 implicit); g = m1(x)*m3(x)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  51  message; bit i = coefficient of x^i of m(x)
- in_valid  in  1  message valid
- in_ready  out  1  encoder can accept a message
- out_bit  out  1  serial codeword bit
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accepts out_bit
- out_last  out  1  marks final (x^0) codeword bit
- out_code  out  63  parallel codeword; bit i = coefficient of x^i of c(x)
- code_valid  out  1  one-cycle pulse: out_code updated

Behaviour:
- Code definition: c(x) = x^12*m(x) + (x^12*m(x) mod g(x)).
  - out_code[62:12] = in_data.
  - out_code[11:0] = parity.
- Reset (rst_n=0 at clk edge):
  - state=IDLE; in_ready=1; out_valid=0; out_last=0; out_bit=0.
  - out_code=0; code_valid=0; parity LFSR=0; counter=0.
  - Reset mid-frame aborts the frame; no partial code_valid.
- FSM states: IDLE, MSG, PAR.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into a shift register, clear the LFSR, counter=0, go to MSG.
- MSG (51 bits):
  - out_valid=1; out_bit = current message MSB (first in_data[50]).
  - On out_valid&out_ready: fb = out_bit ^ lfsr[11]; lfsr = (lfsr<<1) ^ (fb ? GEN_POLY : 0).
  - On the same accepted bit: shift the message, counter++.
  - After the 51st accepted bit: counter=0, go to PAR.
- PAR (12 bits):
  - out_valid=1; out_bit = lfsr[11].
  - On accepted bit: lfsr<<=1, counter++.
  - out_last=1 while counter==11.
  - On the accepted last bit: go to IDLE, pulse code_valid, load out_code.
- Handshake:
  - out_bit, out_valid and out_last stay stable while out_valid&!out_ready.
  - Nothing advances without acceptance.
  - in_ready=0 in MSG and PAR.
  - in_valid is ignored outside IDLE; the source must hold in_data until acceptance.
- Latency:
  - First codeword bit valid the cycle after input acceptance.
  - Full codeword takes 63 accepted beats.
  - in_ready rises the cycle after the last accept, giving a minimum 64-cycle period per frame with out_ready=1.
- out_code holds its value until the next code_valid.
- The codeword is built from the latched message plus the final LFSR, not from in_data.
- Every emitted codeword has zero syndromes S1 and S3 under bch_decoder's convention (bit i weights alpha^i).

Decomposition:
- Package bch_pkg holds:
  - BCH_N=63, BCH_K=51, BCH_PARITY=12
  - BCH_GEN_POLY=12'h539
  - GF_PRIM_POLY=7'h43
  - typedef gf6_t (logic[5:0])
  - typedef bch_msg_t (logic[50:0]), typedef bch_code_t (logic[62:0])
  - enum enc_state_t
- One sub-module is natural: bch_parity_lfsr (clear, shift_en, data_in, feedback_en, parity[11:0]).
  - feedback_en=0 in PAR gives a plain shift.

Test Plan:
- in_data=0, out_ready=1 → 63 zero bits; out_last on beat 63; code_valid with out_code=63'h0.
- in_data=51'h1 → out_code=63'h1539; serial stream = 50 zeros, 1, then parity 0101_0011_1001.
- in_data=51'h3 → out_code=63'h3F4B.
- Random out_ready (~40% low), random messages → stream and out_code match the golden model; outputs stable while stalled; the bch_decoder syndromes recompute to S1=S3=0.
- in_valid held high continuously → back-to-back frames, in_ready pulses once per frame; a second in_data change during MSG has no effect.
- Assert rst_n=0 on beat 30 of a frame → next cycle out_valid=0, in_ready=1; no code_valid; next frame encodes correctly.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,51) t=2 codec over GF(2^6).
package bch_pkg;
    localparam int BCH_N      = 63;
    localparam int BCH_K      = 51;
    localparam int BCH_PARITY = 12;

    // g(x) = x^12 + x^10 + x^8 + x^5 + x^4 + x^3 + 1, x^12 implicit
    localparam logic [BCH_PARITY-1:0] BCH_GEN_POLY = 12'h539;
    localparam logic [6:0]            GF_PRIM_POLY = 7'h43;

    typedef logic [5:0]       gf6_t;
    typedef logic [BCH_K-1:0] bch_msg_t;
    typedef logic [BCH_N-1:0] bch_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MSG,
        ST_PAR
    } enc_state_t;
endpackage

// File: rtl/bch_parity_lfsr.sv
// Division-by-g(x) register; with feedback disabled it degrades to a plain
// left shift so the remainder can be streamed out MSB first.
module bch_parity_lfsr
    import bch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  data_in,
    input  logic                  feedback_en,
    output logic [BCH_PARITY-1:0] parity
);
    logic [BCH_PARITY-1:0] parity_q, parity_d;
    logic                  fb;

    always_comb begin
        fb       = feedback_en & (data_in ^ parity_q[BCH_PARITY-1]);
        parity_d = parity_q;
        if (clear)
            parity_d = '0;
        else if (shift_en)
            parity_d = {parity_q[BCH_PARITY-2:0], 1'b0} ^ (fb ? BCH_GEN_POLY : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) parity_q <= '0;
        else        parity_q <= parity_d;
    end

    assign parity = parity_q;
endmodule

// File: rtl/bch_encoder.sv
// Systematic BCH(63,51) encoder: takes a message word, streams the codeword
// MSB first over valid/ready, then presents the whole codeword in parallel.
module bch_encoder
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [50:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_bit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [62:0] out_code,
    output logic        code_valid
);
    enc_state_t            state_q, state_d;
    bch_msg_t              msg_q, msg_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [BCH_PARITY-2:0] par_sr_q, par_sr_d;
    bch_code_t             out_code_q, out_code_d;
    logic                  code_valid_q, code_valid_d;

    logic                  lfsr_clear, lfsr_shift, lfsr_fb_en;
    logic [BCH_PARITY-1:0] parity;

    bch_parity_lfsr u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (lfsr_clear),
        .shift_en    (lfsr_shift),
        .data_in     (out_bit),
        .feedback_en (lfsr_fb_en),
        .parity      (parity)
    );

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        cnt_d        = cnt_q;
        par_sr_d     = par_sr_q;
        out_code_d   = out_code_q;
        code_valid_d = 1'b0;
        lfsr_clear   = 1'b0;
        lfsr_shift   = 1'b0;
        lfsr_fb_en   = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_bit      = 1'b0;
        out_last     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    msg_d      = in_data;
                    lfsr_clear = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_MSG;
                end
            end
            ST_MSG: begin
                out_valid  = 1'b1;
                out_bit    = msg_q[BCH_K-1];
                lfsr_fb_en = 1'b1;
                if (out_ready) begin
                    lfsr_shift = 1'b1;
                    // Rotate rather than shift: after 51 beats the message is back intact.
                    msg_d = {msg_q[BCH_K-2:0], msg_q[BCH_K-1]};
                    if (cnt_q == 6'(BCH_K - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PAR;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_PAR: begin
                out_valid = 1'b1;
                out_bit   = parity[BCH_PARITY-1];
                out_last  = (cnt_q == 6'(BCH_PARITY - 1));
                if (out_ready) begin
                    lfsr_shift = 1'b1;
                    par_sr_d   = {par_sr_q[BCH_PARITY-3:0], out_bit};
                    cnt_d      = cnt_q + 6'd1;
                    if (out_last) begin
                        cnt_d        = '0;
                        state_d      = ST_IDLE;
                        code_valid_d = 1'b1;
                        out_code_d   = {msg_q, par_sr_q, out_bit};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            msg_q        <= '0;
            cnt_q        <= '0;
            par_sr_q     <= '0;
            out_code_q   <= '0;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            cnt_q        <= cnt_d;
            par_sr_q     <= par_sr_d;
            out_code_q   <= out_code_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign out_code   = out_code_q;
    assign code_valid = code_valid_q;
endmodule

// File: tb/tb_bch_encoder.sv
// Bench for bch_encoder: known vectors, random stalls against a polynomial-
// division reference, back-to-back frames and a mid-frame reset.
module tb_bch_encoder;
    import bch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [50:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_bit, out_valid, out_last, code_valid;
    logic        out_ready = 1'b1;
    logic [62:0] out_code;

    int checks = 0;
    int errors = 0;
    gf6_t pw[63];

    typedef struct {
        bch_msg_t  msg;
        bch_code_t code;
    } vec_t;
    vec_t vt[3];

    bch_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_code(out_code),
        .code_valid(code_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Long division of x^12*m(x) by g(x)
    function automatic bch_code_t ref_code(input bch_msg_t m);
        logic [62:0] r, g;
        r = {m, 12'b0};
        g = 63'h1539;
        for (int i = 62; i >= 12; i--)
            if (r[i]) r = r ^ (g << (i - 12));
        return {m, r[11:0]};
    endfunction

    function automatic logic [11:0] syndromes(input bch_code_t c);
        gf6_t s1, s3;
        s1 = '0;
        s3 = '0;
        for (int i = 0; i < 63; i++)
            if (c[i]) begin
                s1 = s1 ^ pw[i];
                s3 = s3 ^ pw[(3 * i) % 63];
            end
        return {s1, s3};
    endfunction

    task automatic do_frame(input bch_msg_t msg, input bch_code_t exp, input int stall_pct,
                            input bit keep_valid, input string tag);
        bch_code_t stream;
        int  beat, cyc, guard;
        bit  last_ok, stable_ok, ready_ok, prev_stall;
        logic pb, pl;
        in_data  = msg;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " accept"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        in_data = bch_msg_t'({$urandom, $urandom});
        stream = '0;
        beat = 0; cyc = 0;
        last_ok = 1; stable_ok = 1; ready_ok = 1; prev_stall = 0;
        pb = 0; pl = 0;
        while (beat < 63 && cyc < 3000) begin
            if (in_ready || code_valid || !out_valid) ready_ok = 0;
            if (prev_stall && (out_bit !== pb || out_last !== pl)) stable_ok = 0;
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_ready) begin
                stream[62 - beat] = out_bit;
                if (out_last !== (beat == 62)) last_ok = 0;
                beat++;
            end
            prev_stall = !out_ready;
            pb = out_bit;
            pl = out_last;
            cyc++;
            @(negedge clk);
        end
        chk({tag, " beats"}, 64'(beat), 64'd63);
        chk({tag, " stream"}, 64'(stream), 64'(exp));
        chk({tag, " out_last"}, 64'(last_ok), 64'd1);
        chk({tag, " stall_stable"}, 64'(stable_ok), 64'd1);
        chk({tag, " busy_flags"}, 64'(ready_ok), 64'd1);
        chk({tag, " code_valid"}, 64'(code_valid), 64'd1);
        chk({tag, " out_code"}, 64'(out_code), 64'(exp));
        chk({tag, " idle_ready"}, 64'({in_ready, out_valid}), 64'b10);
        chk({tag, " syndromes"}, 64'(syndromes(out_code)), 64'd0);
        if (stall_pct == 0) chk({tag, " cycles"}, 64'(cyc), 64'd63);
        out_ready = 1'b1;
    endtask

    initial begin
        bch_msg_t m;
        int  beat, guard;
        bit  no_pulse;
        pw[0] = 6'h01;
        for (int i = 1; i < 63; i++)
            pw[i] = {pw[i-1][4:0], 1'b0} ^ (pw[i-1][5] ? GF_PRIM_POLY[5:0] : 6'h00);

        vt[0] = '{51'h0, 63'h0};
        vt[1] = '{51'h1, 63'h1539};
        vt[2] = '{51'h3, 63'h3F4B};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_last", 64'(out_last), 64'd0);
        chk("reset out_bit", 64'(out_bit), 64'd0);
        chk("reset out_code", 64'(out_code), 64'd0);
        chk("reset code_valid", 64'(code_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++)
            do_frame(vt[i].msg, vt[i].code, 0, 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            m = bch_msg_t'({$urandom, $urandom});
            do_frame(m, ref_code(m), 40, 0, $sformatf("rand%0d", i));
        end
        chk("out_code hold", 64'(out_code), 64'(ref_code(m)));

        for (int i = 0; i < 4; i++) begin
            m = bch_msg_t'({$urandom, $urandom});
            do_frame(m, ref_code(m), 0, 1, $sformatf("b2b%0d", i));
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Abort a frame after 30 accepted beats
        in_data  = bch_msg_t'({$urandom, $urandom});
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        @(negedge clk);
        in_valid = 1'b0;
        beat = 0; guard = 0;
        while (beat < 30 && guard < 200) begin
            if (out_valid) beat++;
            guard++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort code_valid", 64'(code_valid), 64'd0);
        rst_n = 1'b1;
        no_pulse = 1;
        for (int i = 0; i < 70; i++) begin
            if (code_valid || out_valid) no_pulse = 0;
            @(negedge clk);
        end
        chk("abort no_code_valid", 64'(no_pulse), 64'd1);
        m = bch_msg_t'({$urandom, $urandom});
        do_frame(m, ref_code(m), 20, 0, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
